// File: rtl/contador_pkg.sv
// contador_pkg: shared definitions for the contador_seq sweep sequencer.
//   state_t   - sequencer state encoding (IDLE, LOAD, RUN, DWELL, DONE)
//   CNT_W     - counter width in bits
//   DWELL_DEF - default number of cycles the count is held at end_val
package contador_pkg;

    localparam int CNT_W     = 4;
    localparam int DWELL_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DWELL,
        S_DONE
    } state_t;

endpackage

// File: rtl/contador_seq_contador.sv
// contador: loadable up/down counter, the single count register of the block.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  synchronous active-high reset, clears the count
//   load     in  load data_in into the count (priority over con)
//   con      in  count enable
//   cup      in  direction: 1 = increment, 0 = decrement
//   data_in  in  CNT_W load value
//   data_out out CNT_W current count
module contador
    import contador_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             con,
    input  logic             cup,
    input  logic [CNT_W-1:0] data_in,
    output logic [CNT_W-1:0] data_out
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= data_in;
        end else if (con) begin
            r_cnt <= cup ? r_cnt + CNT_W'(1) : r_cnt - CNT_W'(1);
        end
    end

    assign data_out = r_cnt;

endmodule

// File: rtl/contador_seq.sv
// contador_seq: sweeps one contador from a captured start value to a captured
// end value, holds it there for DWELL cycles and pulses done.
// Optional feature (macro CONTADOR_SEQ_PINGPONG_EN): after the dwell the
// counter sweeps back to the start value before done (no second dwell).
// Parameters:
//   DWELL     cycles the count is held at end_val before completion (0 allowed)
// Ports:
//   clk       in  system clock, rising edge
//   rst       in  synchronous active-high reset
//   start     in  begin a sweep (sampled only in IDLE)
//   abort     in  terminate sweep, return to IDLE, count held
//   pause     in  freeze counting while high (RUN only)
//   start_val in  first count value, captured on accepted start
//   end_val   in  target count value, captured on accepted start
//   count     out current counter value
//   dir       out 1 = counting up, 0 = down
//   busy      out high in every state except IDLE
//   done      out one-cycle completion pulse
module contador_seq
    import contador_pkg::*;
#(
    parameter int DWELL = DWELL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic [CNT_W-1:0] start_val,
    input  logic [CNT_W-1:0] end_val,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done
);

    // Dwell counter sized so DWELL-1 fits; at least one bit when DWELL is 0.
    localparam int             DCW        = $clog2(DWELL + 2);
    localparam logic [DCW-1:0] DWELL_LAST = DCW'((DWELL > 0) ? DWELL - 1 : 0);
    localparam bit             HAS_DWELL  = (DWELL > 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_start;
    logic [CNT_W-1:0] r_end;
    logic             r_dir;
    logic [DCW-1:0]   r_dwell;

    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_target;
    logic             w_at_target;
    logic             w_load;
    logic             w_con;

`ifdef CONTADOR_SEQ_PINGPONG_EN
    logic             r_leg;   // 0 = outbound leg, 1 = return leg
    logic             w_turn;
    assign w_target = r_leg ? r_start : r_end;
`else
    assign w_target = r_end;
`endif

    assign w_at_target = (w_cnt == w_target);

    contador u_contador (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .con      (w_con),
        .cup      (r_dir),
        .data_in  (r_start),
        .data_out (w_cnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_con       = 1'b0;
`ifdef CONTADOR_SEQ_PINGPONG_EN
        w_turn      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!w_at_target) begin
                    w_con = ~pause;
`ifdef CONTADOR_SEQ_PINGPONG_EN
                end else if (!r_leg && HAS_DWELL) begin
                    w_state_nxt = S_DWELL;
                end else if (!r_leg) begin
                    w_turn      = 1'b1;
                    w_state_nxt = S_RUN;
`else
                end else if (HAS_DWELL) begin
                    w_state_nxt = S_DWELL;
`endif
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DWELL: begin
                if (r_dwell == DWELL_LAST) begin
`ifdef CONTADOR_SEQ_PINGPONG_EN
                    w_turn      = 1'b1;
                    w_state_nxt = S_RUN;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides every other decision, including reaching target.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_load      = 1'b0;
            w_con       = 1'b0;
`ifdef CONTADOR_SEQ_PINGPONG_EN
            w_turn      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_start <= '0;
            r_end   <= '0;
            r_dir   <= 1'b1;
            r_dwell <= '0;
`ifdef CONTADOR_SEQ_PINGPONG_EN
            r_leg   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && start) begin
                r_start <= start_val;
                r_end   <= end_val;
                r_dir   <= (end_val >= start_val);
`ifdef CONTADOR_SEQ_PINGPONG_EN
                r_leg   <= 1'b0;
`endif
            end
`ifdef CONTADOR_SEQ_PINGPONG_EN
            if (w_turn) begin
                r_leg <= 1'b1;
                r_dir <= ~r_dir;
            end
`endif
            if (r_state == S_DWELL) begin
                r_dwell <= r_dwell + DCW'(1);
            end else begin
                r_dwell <= '0;
            end
        end
    end

    assign count = w_cnt;
    assign dir   = r_dir;
    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);

endmodule

// File: tb/tb_contador_seq.sv
// tb_contador_seq: directed and randomized sweeps of contador_seq checked
// edge by edge against a trajectory model built from the sweep rules.
module tb_contador_seq;

    localparam int DWELL_TB = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       pause;
    logic [3:0] start_val;
    logic [3:0] end_val;
    logic [3:0] count;
    logic       dir;
    logic       busy;
    logic       done;

    int         n_assert;
    int         n_fail;
    logic [3:0] prev_count;

    contador_seq #(.DWELL(DWELL_TB)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pause     (pause),
        .start_val (start_val),
        .end_val   (end_val),
        .count     (count),
        .dir       (dir),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [3:0] got, input logic [3:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s edge %0d: observed %0d expected %0d", tag, k, got, exp);
        end
    endtask

    // Runs one sweep from IDLE. pm[k] drives pause during the cycle after
    // edge k; ab_k / rs_k (-1 = none) drive abort / rst during that cycle.
    // start stays high while busy with junk values to show it is ignored.
    task automatic sweep(input logic [3:0] s, input logic [3:0] e, input bit [63:0] pm,
                         input int ab_k_in, input int rs_k_in);
        logic [3:0] ec [0:95];
        logic       eb [0:95];
        logic       ed [0:95];
        logic       edr[0:95];
        logic [3:0] c;
        bit         up;
        int         k, L, ab_k, rs_k;

        ab_k = ab_k_in;
        rs_k = rs_k_in;
        up   = (e >= s);
        for (int i = 0; i < 96; i++) begin
            ec[i] = prev_count; eb[i] = 1'b1; ed[i] = 1'b0; edr[i] = up;
        end
        // Outbound leg: count = s after edge 1, one step per unpaused cycle.
        c = s; k = 1; ec[1] = s;
        while (c != e) begin
            if (k >= 64 || !pm[k]) c = up ? c + 4'd1 : c - 4'd1;
            k++;
            ec[k] = c;
        end
        // Target-detect cycle, then DWELL cycles holding e.
        for (int j = k + 1; j <= k + 1 + DWELL_TB; j++) ec[j] = e;
        k = k + 1 + DWELL_TB;
`ifdef CONTADOR_SEQ_PINGPONG_EN
        for (int j = k; j < 96; j++) edr[j] = ~up;
        while (c != s) begin
            if (k >= 64 || !pm[k]) c = up ? c - 4'd1 : c + 4'd1;
            k++;
            ec[k] = c;
        end
        k = k + 1;
        ec[k] = s;
`endif
        ed[k] = 1'b1;
        L = k + 1;
        ec[L] = ec[k]; eb[L] = 1'b0;

        if (ab_k >= 0 && ab_k < L - 1) begin
            L = ab_k + 1; ec[L] = ec[ab_k]; eb[L] = 1'b0; ed[L] = 1'b0;
        end else begin
            ab_k = -1;
        end
        if (rs_k >= 0 && rs_k < L) begin
            L = rs_k + 1; ec[L] = 4'd0; eb[L] = 1'b0; ed[L] = 1'b0; edr[L] = 1'b1;
        end else begin
            rs_k = -1;
        end

        start = 1'b1; start_val = s; end_val = e; pause = 1'b0; abort = 1'b0; rst = 1'b0;
        for (int kk = 0; kk <= L; kk++) begin
            @(posedge clk); #1;
            chk("count", kk, count, ec[kk]);
            chk("busy",  kk, {3'b0, busy}, {3'b0, eb[kk]});
            chk("done",  kk, {3'b0, done}, {3'b0, ed[kk]});
            chk("dir",   kk, {3'b0, dir},  {3'b0, edr[kk]});
            start_val = 4'($urandom);
            end_val   = 4'($urandom);
            start     = (kk < L);
            pause     = (kk < 64) ? pm[kk] : 1'b0;
            abort     = (kk == ab_k);
            rst       = (kk == rs_k);
        end
        start = 1'b0; pause = 1'b0; abort = 1'b0; rst = 1'b0;
        prev_count = ec[L];
    endtask

    initial begin
        bit [63:0] pm;
        int        ab;
        n_assert = 0; n_fail = 0; prev_count = 4'd0;
        rst = 1'b1; start = 1'b1; abort = 1'b0; pause = 1'b0;
        start_val = 4'd7; end_val = 4'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 0, count, 4'd0);
        chk("rst_busy",  0, {3'b0, busy}, 4'd0);
        chk("rst_done",  0, {3'b0, done}, 4'd0);
        chk("rst_dir",   0, {3'b0, dir},  4'd1);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", 0, {3'b0, busy}, 4'd0);

        sweep(4'd1,  4'd8,  64'd0, -1, -1);                   // basic up sweep
        sweep(4'd10, 4'd7,  64'd0, -1, -1);                   // down sweep
        sweep(4'd0,  4'd15, 64'h1C0, -1, -1);                 // pause 3 cycles at count 5
        sweep(4'd2,  4'd9,  64'd0, 3, -1);                    // abort at count 4
        sweep(4'd3,  4'd12, 64'd0, -1, 4);                    // reset at count 6
        sweep(4'd5,  4'd5,  64'd0, -1, -1);                   // start == end
        sweep(4'd15, 4'd0,  64'hFFFF_FFFF_FFFF_FFFF, -1, -1); // pause outside RUN only matters in RUN
        sweep(4'd6,  4'd9,  64'd0, 0, -1);                    // abort during LOAD

        for (int t = 0; t < 12; t++) begin
            pm = {$urandom, $urandom} & {$urandom, $urandom};
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
            sweep(4'($urandom), 4'($urandom), pm, ab, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/contador_seq.md
CONTADOR_SEQ -- requirements
Module: contador_seq

Interface
REQ-001 SHALL have parameter DWELL, default 2: cycles the count is held at end_val before completion (0 allowed).
REQ-002 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  begin sweep, sampled only in IDLE.
REQ-005 SHALL have port abort  in  1  terminate sweep, return to IDLE.
REQ-006 SHALL have port pause  in  1  freeze counting while high.
REQ-007 SHALL have port start_val  in  4  first count value, captured on accepted start.
REQ-008 SHALL have port end_val  in  4  target count value, captured on accepted start.
REQ-009 SHALL have port count  out  4  current counter value.
REQ-010 SHALL have port dir  out  1  1 = counting up, 0 = down.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.

Function
REQ-013 SHALL sequence one internal contador via load, con, cup and data_in only; count is contador's data_out.
REQ-014 SHALL implement states IDLE, LOAD, RUN, DWELL and DONE.
REQ-015 IDLE: start=1 at an edge SHALL capture start_val/end_val; next state LOAD; start ignored in all other states.
REQ-016 LOAD: load=1 and data_in=captured start for exactly one cycle; next state RUN; count = start at that edge.
REQ-017 dir SHALL be set at capture: 1 if end >= start, else 0; cup = dir.
REQ-018 RUN: con=1 only when pause=0 and count != target; count changes by exactly 1 per unpaused cycle.
REQ-019 RUN with count == target SHALL assert con=0 (no overshoot, no wrap) and move to DWELL if DWELL>0, else DONE.
REQ-020 DWELL SHALL hold count (con=0) for exactly DWELL cycles; pause does not extend DWELL.
REQ-021 DONE SHALL assert done for one cycle; next state IDLE; count held.
REQ-022 start == end SHALL skip counting: LOAD -> RUN -> DWELL/DONE.
REQ-023 Latency: done high in the cycle after edge 2+|end-start|+DWELL, counted from the start-sampling edge (edge 0), given no pause.
REQ-024 abort=1 in any non-IDLE state SHALL force con=0 and load=0, return to IDLE next edge, hold count, never assert done; abort has priority over pause and over reaching target.
REQ-025 pause in states other than RUN SHALL have no effect.

Reset
REQ-026 rst=1 SHALL force IDLE, reset the contador (count=0), dir=1, busy=0, done=0, and clear captured values, taking priority over all inputs including mid-sweep.

Configuration
REQ-027 Macro CONTADOR_SEQ_PINGPONG_EN defined SHALL add a return leg: after DWELL, RUN again with dir inverted and target = start, then DONE with no second dwell; latency grows by |end-start|+1.
REQ-028 Without CONTADOR_SEQ_PINGPONG_EN the block SHALL complete after the first leg, and no phase state SHALL exist.

Structure
REQ-029 Package contador_pkg SHALL hold the state enum typedef, the CNT_W=4 width constant and the default DWELL value.
REQ-030 Sub-module contador SHALL be instantiated once; contador_seq SHALL add no second counter register for count.

Verification
REQ-031 start_val=1, end_val=8, DWELL=2, start at edge 0 -> count 1..8 one step per cycle; done high after edge 11 (2+7+2); busy low afterwards.
REQ-032 start_val=10, end_val=7 -> dir=0; count 10,9,8,7 then held; done exactly once.
REQ-033 Sweep 0->15 with pause high for 3 cycles at count=5 -> count stays 5 for 3 cycles; done delayed by 3; count stops at 15, never wraps to 0.
REQ-034 abort at count=4 of a 2->9 sweep -> IDLE next edge, count stays 4, done never asserted; new start accepted the following cycle.
REQ-035 rst pulsed at count=6 of a 3->12 sweep -> count=0, busy=0 after that edge; start held high during busy is ignored.
REQ-036 With CONTADOR_SEQ_PINGPONG_EN, 2->5, DWELL=0 -> count 2,3,4,5,5,4,3,2; done after edge 9 (2+3+0+4).
